game_state_ctrl: RTL and testbench

Parametrised game-state controller for the mole game; successor to `gsm`. Holds game state, stage, lives, score, high score and the per-second countdown timer. It accepts commands from the game logic over a valid/ready handshake. Ready-countdown expiry, play-time expiry and the last life being lost drive state transitions on their own, so the top-level FSM only issues hits, misses and menu commands.

---
 rtl/game_state_ctrl_if.sv | 19 +
 rtl/game_state_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_state_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : game_state_ctrl_if
// Brief  : Command valid/ready channel from the game logic to game_state_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
interface game_state_ctrl_if #(
  parameter int PTS_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd;
  logic [PTS_W-1:0] cmd_pts;
  logic             cmd_err;

  modport master (output cmd_valid, cmd, cmd_pts, input cmd_ready, cmd_err);
  modport slave  (input cmd_valid, cmd, cmd_pts, output cmd_ready, cmd_err);
endinterface
`default_nettype wire

// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module : game_state_ctrl
// Brief  : Mole-game state, stage, lives, score and countdown controller.
//          Optional combo multiplier enabled by defining GSM_COMBO_EN.
// Rev    : 1.0  initial release
// ============================================================================
module game_state_ctrl #(
  parameter  int CLK_HZ    = 1000000,
  parameter  int MAX_STAGE = 3,
  parameter  int MAX_LIVES = 3,
  parameter  int SCORE_W   = 10,
  parameter  int PTS_W     = 4,
  parameter  int READY_SEC = 4,
  parameter  int PLAY_SEC  = 60,
  parameter  int TIMER_W   = 7,
  localparam int STAGE_W   = $clog2(MAX_STAGE + 1),
  localparam int LIFE_W    = $clog2(MAX_LIVES + 1)
) (
  input  wire logic         clk_1mhz,
  input  wire logic         rst_n,
  game_state_ctrl_if.slave  cmd_if,
  output logic [2:0]         state,
  output logic [STAGE_W-1:0] stage,
  output logic [LIFE_W-1:0]  lives,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               hs_updated,
  output logic [TIMER_W-1:0] timer,
  output logic               timer_running,
  output logic               sec_tick,
  output logic [1:0]         combo
);

  typedef enum logic [2:0] {
    ST_READY   = 3'd1,
    ST_PLAYING = 3'd2,
    ST_OVER    = 3'd3,
    ST_SCLEAR  = 3'd4,
    ST_GCLEAR  = 3'd5
  } state_e;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_HIT     = 3'd1;
  localparam logic [2:0] CMD_MISS    = 3'd2;
  localparam logic [2:0] CMD_PAUSE   = 3'd3;
  localparam logic [2:0] CMD_RESUME  = 3'd4;
  localparam logic [2:0] CMD_START   = 3'd5;
  localparam logic [2:0] CMD_NEXT    = 3'd6;
  localparam logic [2:0] CMD_RESTART = 3'd7;

  localparam int PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int PTS_EFF_W = PTS_W + 3;
  localparam int SUM_W     = ((SCORE_W > PTS_EFF_W) ? SCORE_W : PTS_EFF_W) + 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [TIMER_W-1:0] READY_T    = TIMER_W'(READY_SEC);
  localparam logic [TIMER_W-1:0] PLAY_T     = TIMER_W'(PLAY_SEC);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_e               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [LIFE_W-1:0]    lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   high_score_q, high_score_d;
  logic                 hs_upd_q, hs_upd_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 running_q, running_d;
  logic [1:0]           combo_q, combo_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 sec_tick_q, sec_tick_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 ready_q;

  logic                 accept;
  logic                 legal;
  logic                 do_cmd;
  logic                 cmd_owns;
  logic                 wrap;
  logic                 game_end;
  logic [PTS_EFF_W-1:0] pts_eff;
  logic [SUM_W-1:0]     score_sum;
  logic [SCORE_W-1:0]   score_hit;

  assign accept = cmd_if.cmd_valid && ready_q;
  assign do_cmd = accept && legal;
  assign wrap   = running_q && (presc_q == PRESC_LAST);

  // Commands that reload the timer or change state pre-empt a coincident expiry.
  assign cmd_owns = do_cmd && ((cmd_if.cmd == CMD_START) || (cmd_if.cmd == CMD_NEXT) ||
                               (cmd_if.cmd == CMD_RESTART) ||
                               ((cmd_if.cmd == CMD_MISS) && (lives_q == LIFE_W'(1))));

  always_comb begin
    case (cmd_if.cmd)
      CMD_NOP, CMD_RESTART:                      legal = 1'b1;
      CMD_HIT, CMD_MISS, CMD_PAUSE, CMD_RESUME:  legal = (state_q == ST_PLAYING);
      CMD_START:                                 legal = (state_q == ST_READY);
      default:                                   legal = (state_q == ST_SCLEAR);
    endcase
  end

`ifdef GSM_COMBO_EN
  assign pts_eff = PTS_EFF_W'(cmd_if.cmd_pts) << combo_q;
`else
  assign pts_eff = PTS_EFF_W'(cmd_if.cmd_pts);
`endif

  assign score_sum = SUM_W'(score_q) + SUM_W'(pts_eff);
  assign score_hit = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    lives_d      = lives_q;
    score_d      = score_q;
    high_score_d = high_score_q;
    hs_upd_d     = hs_upd_q;
    timer_d      = timer_q;
    running_d    = running_q;
    combo_d      = combo_q;
    presc_d      = (running_q && !wrap) ? presc_q + 1'b1 : '0;
    sec_tick_d   = 1'b0;
    cmd_err_d    = accept && !legal;
    game_end     = 1'b0;

    if (wrap && (timer_q != '0) && !cmd_owns) begin
      timer_d    = timer_q - 1'b1;
      sec_tick_d = 1'b1;
      if (timer_q == TIMER_W'(1)) begin
        if (state_q == ST_READY) begin
          state_d = ST_PLAYING;
          timer_d = PLAY_T;
        end else if (state_q == ST_PLAYING) begin
          state_d   = (stage_q < STAGE_W'(MAX_STAGE)) ? ST_SCLEAR : ST_GCLEAR;
          running_d = 1'b0;
          game_end  = (stage_q >= STAGE_W'(MAX_STAGE));
        end
      end
    end

    // Applied after the timer so the command wins for state, timer and run flag.
    if (do_cmd) begin
      case (cmd_if.cmd)
        CMD_HIT: begin
          score_d = score_hit;
`ifdef GSM_COMBO_EN
          if (combo_q != 2'd3) combo_d = combo_q + 2'd1;
`endif
        end
        CMD_MISS: begin
          lives_d = lives_q - 1'b1;
          combo_d = 2'd0;
          if (lives_q == LIFE_W'(1)) begin
            state_d   = ST_OVER;
            running_d = 1'b0;
            game_end  = 1'b1;
          end
        end
        CMD_PAUSE: begin
          running_d = 1'b0;
          presc_d   = '0;
        end
        CMD_RESUME: begin
          running_d = 1'b1;
          presc_d   = '0;
        end
        CMD_START: begin
          state_d   = ST_PLAYING;
          timer_d   = PLAY_T;
          running_d = 1'b1;
          presc_d   = '0;
        end
        CMD_NEXT: begin
          stage_d   = stage_q + 1'b1;
          state_d   = ST_READY;
          timer_d   = READY_T;
          running_d = 1'b1;
          presc_d   = '0;
          hs_upd_d  = 1'b0;
        end
        CMD_RESTART: begin
          state_d   = ST_READY;
          stage_d   = STAGE_W'(1);
          lives_d   = LIFE_W'(MAX_LIVES);
          score_d   = '0;
          combo_d   = 2'd0;
          timer_d   = READY_T;
          running_d = 1'b1;
          presc_d   = '0;
          hs_upd_d  = 1'b0;
        end
        default: ;
      endcase
    end

    if (state_d != state_q) combo_d = 2'd0;

    // Uses the post-HIT score so a final hit still counts toward the record.
    if (game_end) begin
      if (score_d > high_score_q) begin
        high_score_d = score_d;
        hs_upd_d     = 1'b1;
      end else begin
        hs_upd_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_READY;
      stage_q      <= STAGE_W'(1);
      lives_q      <= LIFE_W'(MAX_LIVES);
      score_q      <= '0;
      high_score_q <= '0;
      hs_upd_q     <= 1'b0;
      timer_q      <= READY_T;
      running_q    <= 1'b1;
      combo_q      <= 2'd0;
      presc_q      <= '0;
      sec_tick_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      high_score_q <= high_score_d;
      hs_upd_q     <= hs_upd_d;
      timer_q      <= timer_d;
      running_q    <= running_d;
      combo_q      <= combo_d;
      presc_q      <= presc_d;
      sec_tick_q   <= sec_tick_d;
      cmd_err_q    <= cmd_err_d;
      ready_q      <= 1'b1;
    end
  end

  assign cmd_if.cmd_ready = ready_q;
  assign cmd_if.cmd_err   = cmd_err_q;
  assign state            = state_q;
  assign stage            = stage_q;
  assign lives            = lives_q;
  assign score            = score_q;
  assign high_score       = high_score_q;
  assign hs_updated       = hs_upd_q;
  assign timer            = timer_q;
  assign timer_running    = running_q;
  assign sec_tick         = sec_tick_q;
  assign combo            = combo_q;

endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_game_state_ctrl
// Brief  : Directed + randomized bench for game_state_ctrl against a rule model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_game_state_ctrl;
  localparam int CLK_HZ    = 10;
  localparam int MAX_STAGE = 2;
  localparam int MAX_LIVES = 3;
  localparam int SCORE_W   = 10;
  localparam int PTS_W     = 4;
  localparam int READY_SEC = 2;
  localparam int PLAY_SEC  = 3;
  localparam int TIMER_W   = 7;
  localparam int STAGE_W   = $clog2(MAX_STAGE + 1);
  localparam int LIFE_W    = $clog2(MAX_LIVES + 1);
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
`ifdef GSM_COMBO_EN
  localparam bit COMBO = 1'b1;
`else
  localparam bit COMBO = 1'b0;
`endif

  logic clk_1mhz = 1'b0;
  logic rst_n;
  game_state_ctrl_if #(.PTS_W(PTS_W)) cmd_if ();

  logic [2:0]         state;
  logic [STAGE_W-1:0] stage;
  logic [LIFE_W-1:0]  lives;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic               hs_updated;
  logic [TIMER_W-1:0] timer;
  logic               timer_running;
  logic               sec_tick;
  logic [1:0]         combo;

  always #5 clk_1mhz = ~clk_1mhz;

  game_state_ctrl #(
    .CLK_HZ(CLK_HZ), .MAX_STAGE(MAX_STAGE), .MAX_LIVES(MAX_LIVES), .SCORE_W(SCORE_W),
    .PTS_W(PTS_W), .READY_SEC(READY_SEC), .PLAY_SEC(PLAY_SEC), .TIMER_W(TIMER_W)
  ) dut (
    .clk_1mhz(clk_1mhz), .rst_n(rst_n), .cmd_if(cmd_if),
    .state(state), .stage(stage), .lives(lives), .score(score),
    .high_score(high_score), .hs_updated(hs_updated), .timer(timer),
    .timer_running(timer_running), .sec_tick(sec_tick), .combo(combo)
  );

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one game's worth of state held as plain integers.
  int m_state, m_stage, m_lives, m_score, m_hs, m_hsu, m_timer, m_run;
  int m_tick, m_err, m_combo, m_ready, m_phase;

  function automatic void model_reset();
    m_state = 1; m_stage = 1; m_lives = MAX_LIVES; m_score = 0; m_hs = 0; m_hsu = 0;
    m_timer = READY_SEC; m_run = 1; m_tick = 0; m_err = 0; m_combo = 0;
    m_ready = 0; m_phase = 0;
  endfunction

  function automatic void model_step(input bit v, input int c, input int p);
    int  prev = m_state;
    bit  acc = v && (m_ready == 1);
    bit  second_done = (m_run == 1) && (m_phase == CLK_HZ - 1);
    bit  ok, claims, run_by_cmd;
    run_by_cmd = 1'b0;
    ok = (c == 0) || (c == 7) || ((c >= 1) && (c <= 4) && (m_state == 2)) ||
         ((c == 5) && (m_state == 1)) || ((c == 6) && (m_state == 4));
    claims = acc && ok && ((c >= 5) || ((c == 2) && (m_lives == 1)));
    m_ready = 1;
    m_tick  = 0;
    m_err   = (acc && !ok) ? 1 : 0;
    m_phase = ((m_run == 1) && !second_done) ? m_phase + 1 : 0;

    if (acc && ok) begin
      case (c)
        1: begin
          m_score += COMBO ? (p << m_combo) : p;
          if (m_score > SCORE_MAX) m_score = SCORE_MAX;
          if (COMBO && m_combo < 3) m_combo++;
        end
        2: begin
          m_lives--; m_combo = 0;
          if (m_lives == 0) begin m_state = 3; m_run = 0; end
        end
        3: begin m_run = 0; m_phase = 0; run_by_cmd = 1'b1; end
        4: begin m_run = 1; m_phase = 0; run_by_cmd = 1'b1; end
        5: begin m_state = 2; m_timer = PLAY_SEC; m_run = 1; m_phase = 0; end
        6: begin m_stage++; m_state = 1; m_timer = READY_SEC; m_run = 1; m_phase = 0; m_hsu = 0; end
        7: begin
          m_state = 1; m_stage = 1; m_lives = MAX_LIVES; m_score = 0; m_combo = 0;
          m_timer = READY_SEC; m_run = 1; m_phase = 0; m_hsu = 0;
        end
        default: ;
      endcase
    end

    if (second_done && !claims && m_timer > 0) begin
      m_tick = 1;
      m_timer--;
      if (m_timer == 0) begin
        if (m_state == 1) begin
          m_state = 2; m_timer = PLAY_SEC;
        end else if (m_state == 2) begin
          m_state = (m_stage < MAX_STAGE) ? 4 : 5;
          if (!run_by_cmd) m_run = 0;
        end
      end
    end

    if (m_state != prev) begin
      m_combo = 0;
      if (m_state == 3 || m_state == 5) begin
        if (m_score > m_hs) begin m_hs = m_score; m_hsu = 1; end
        else m_hsu = 0;
      end
    end
  endfunction

  task automatic compare_all();
    check("ready", int'(cmd_if.cmd_ready), m_ready);
    check("cmd_err", int'(cmd_if.cmd_err), m_err);
    check("state", int'(state), m_state);
    check("stage", int'(stage), m_stage);
    check("lives", int'(lives), m_lives);
    check("score", int'(score), m_score);
    check("high_score", int'(high_score), m_hs);
    check("hs_updated", int'(hs_updated), m_hsu);
    check("timer", int'(timer), m_timer);
    check("timer_running", int'(timer_running), m_run);
    check("sec_tick", int'(sec_tick), m_tick);
    check("combo", int'(combo), m_combo);
  endtask

  task automatic cyc(input bit v, input int c, input int p);
    cmd_if.cmd_valid = v;
    cmd_if.cmd       = 3'(c);
    cmd_if.cmd_pts   = PTS_W'(p);
    model_step(v, c, p);
    @(posedge clk_1mhz);
    #1;
    if (sec_tick) tick_cnt++;
    compare_all();
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0);
  endtask

  task automatic send(input int c, input int p);
    cyc(1'b1, c, p);
  endtask

  task automatic idle_until(input int st);
    for (int i = 0; i < 200 && m_state != st; i++) idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_sc;
    int n;
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd = 3'd0;
    cmd_if.cmd_pts = '0;
    model_reset();
    repeat (3) @(posedge clk_1mhz);
    #1;
    compare_all();
    #3 rst_n = 1'b1;

    // Reset then idle: READY -> PLAYING after two seconds.
    tick_cnt = 0;
    repeat (20) idle();
    check("idle_state", int'(state), 2);
    check("idle_timer", int'(timer), PLAY_SEC);
    check("idle_ticks", tick_cnt, 2);

    // Three hits of 5 points.
    exp_sc = 0;
    for (int k = 0; k < 3; k++) begin
      send(1, 5);
      exp_sc += COMBO ? (5 << k) : 5;
      check("hit_score", int'(score), exp_sc);
    end
    check("hit_combo", int'(combo), COMBO ? 3 : 0);
    send(2, 0);
    check("miss_lives", int'(lives), 2);
    check("miss_combo", int'(combo), 0);
    send(2, 0);
    send(2, 0);
    check("over_state", int'(state), 3);
    check("over_lives", int'(lives), 0);
    check("over_hs", int'(high_score), exp_sc);
    check("over_hsu", int'(hs_updated), 1);

    // Illegal START in OVER.
    send(5, 0);
    check("illegal_err", int'(cmd_if.cmd_err), 1);
    check("illegal_state", int'(state), 3);
    idle();
    check("illegal_err_pulse", int'(cmd_if.cmd_err), 0);

    // Stage progression to game clear.
    send(7, 0);
    check("restart_hsu", int'(hs_updated), 0);
    idle_until(4);
    check("sclear_state", int'(state), 4);
    send(6, 0);
    check("next_state", int'(state), 1);
    check("next_stage", int'(stage), 2);
    idle_until(5);
    check("gclear_state", int'(state), 5);
    check("gclear_hs_kept", int'(high_score), exp_sc);

    // Pause mid-second, resume restarts the partial second.
    send(7, 0);
    idle_until(2);
    repeat (5) idle();
    send(3, 0);
    repeat (50) idle();
    check("pause_timer", int'(timer), PLAY_SEC);
    send(4, 0);
    n = 0;
    do begin
      idle();
      n++;
    end while (sec_tick == 1'b0 && n < 40);
    check("resume_tick_delay", n, 10);

    // Randomized command mix.
    repeat (1500) begin
      int r = $urandom_range(0, 99);
      bit v = ($urandom_range(0, 9) != 0);
      int c;
      if (r < 35)      c = 0;
      else if (r < 62) c = 1;
      else if (r < 67) c = 2;
      else if (r < 72) c = 3;
      else if (r < 79) c = 4;
      else if (r < 85) c = 5;
      else if (r < 91) c = 6;
      else if (r < 94) c = 7;
      else             c = $urandom_range(0, 7);
      cyc(v, c, $urandom_range(0, 15));
    end

    // Asynchronous reset mid-PLAYING.
    send(7, 0);
    idle_until(2);
    send(1, 9);
    repeat (3) idle();
    #3 rst_n = 1'b0;
    #1;
    check("arst_state", int'(state), 1);
    check("arst_stage", int'(stage), 1);
    check("arst_lives", int'(lives), MAX_LIVES);
    check("arst_score", int'(score), 0);
    check("arst_hs", int'(high_score), 0);
    check("arst_timer", int'(timer), READY_SEC);
    check("arst_running", int'(timer_running), 1);
    check("arst_ready", int'(cmd_if.cmd_ready), 0);
    model_reset();
    @(posedge clk_1mhz);
    @(posedge clk_1mhz);
    #1;
    compare_all();
    #3 rst_n = 1'b1;
    repeat (40) cyc(1'b1, $urandom_range(0, 1), $urandom_range(0, 15));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
